// File: rtl/interval_sched_pkg.sv
// Shared constants for the interval scheduler: FSM encoding, default sizes, helpers.
// Defining INTERVAL_SCHED_PRIO_EN gives requester 0 fixed top priority.
package interval_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef INTERVAL_SCHED_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
// With INTERVAL_SCHED_PRIO_EN, index 0 wins outright and is skipped by the rotating scan.
module rr_pick
  import interval_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    if (PRIO_EN && req[0]) begin
      valid = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!valid && req[idx] && !(PRIO_EN && idx == 0)) begin
          valid  = 1'b1;
          winner = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/interval_sched.sv
// Shares one interval counter among NREQ requesters: arbitrate, run a len-cycle window, pulse done.
// Arbitration policy is selected by INTERVAL_SCHED_PRIO_EN (see interval_sched_pkg).
module interval_sched
  import interval_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      value,
  output logic [NREQ-1:0]       done
);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    pick;
  logic             pick_valid;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] len_l;
  logic             finish;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  // Zero length is a one-cycle window; early release ends the window at the same edge.
  assign finish = (len_l == '0) || (cnt == len_l - WIDTH'(1)) || !req[winner];

  assign busy  = (state != S_IDLE);
  assign value = (state == S_IDLE) ? '0 : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      done   <= '0;
      cnt    <= '0;
      len_l  <= '0;
      rr_ptr <= '0;
      winner <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state       <= S_RUN;
            grant       <= '0;
            grant[pick] <= 1'b1;
            winner      <= pick;
            len_l       <= len[pick*WIDTH +: WIDTH];
            cnt         <= '0;
          end
        end
        S_RUN: begin
          if (finish) begin
            state        <= S_DONE;
            grant        <= '0;
            done[winner] <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (!PRIO_EN || winner != '0)
            rr_ptr <= IW'(wrap_inc(int'(winner), NREQ));
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
`endif

endmodule

// File: tb/tb_interval_sched.sv
// Self-checking bench for interval_sched: reset sequence, then a table of windows with a scoreboard.
// Expected winners follow INTERVAL_SCHED_PRIO_EN when the bench is built with it.
module tb_interval_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef INTERVAL_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] len = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  value;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    int          rel;     // drop req[winner] after seeing this count (-1: hold)
    bit          scr;     // scramble len after the grant edge
    int          w;
    int          wp;
    int          cycles;
    int          last;
    int          gap;
  } vec_t;

  typedef struct {
    int w;
    int cycles;
    int last;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  interval_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .busy  (busy),
    .value (value),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lens(input int l3, input int l2, input int l1, input int l0);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic add(input logic [3:0] r, input logic [31:0] l, input int rel, input bit scr,
                     input int w, input int wp, input int cyc, input int last, input int gap);
    vec_t v;
    v.req = r; v.len = l; v.rel = rel; v.scr = scr;
    v.w = w; v.wp = wp; v.cycles = cyc; v.last = last; v.gap = gap;
    vecs.push_back(v);
  endtask

  task automatic run_entry(input vec_t v);
    exp_t e;
    exp_t got;
    int   gap;
    int   cnt;
    int   w;
    req = v.req;
    len = v.len;
    e.w = PRIO ? v.wp : v.w;
    e.cycles = v.cycles;
    e.last = v.last;
    sb.push_back(e);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
      if (grant == '0) begin
        check("idle_value", int'(value), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
      end
    end while (grant == '0 && gap < 20);
    if (grant == '0) begin
      check("grant_timeout", 0, 1);
      void'(sb.pop_front());
      return;
    end
    check("arb_gap", gap, v.gap);
    check("grant_onehot", $countones(grant), 1);
    w = 0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) w = i;
    if (v.scr) len = ~len;
    cnt = 0;
    while (grant != '0 && cnt < 300) begin
      check("run_value", int'(value), cnt);
      check("run_busy", int'(busy), 1);
      check("run_done", int'(done), 0);
      check("run_grant", int'(grant), 1 << w);
      if (v.rel == cnt) req[w] = 1'b0;
      cnt++;
      @(posedge clk); #1;
    end
    if (grant != '0) check("window_timeout", 0, 1);
    check("done_pulse", int'(done), 1 << w);
    check("done_busy", int'(busy), 1);
    got.w = w;
    got.cycles = cnt;
    got.last = int'(value);
    e = sb.pop_front();
    check("winner", got.w, e.w);
    check("grant_cycles", got.cycles, e.cycles);
    check("last_value", got.last, e.last);
  endtask

  initial begin
    //   req      len                   rel scr w  wp cyc  last gap
    add(4'b1001, lens(0, 0, 0, 4),     -1, 0, 0, 0, 4,   3,   1);
    add(4'b0010, lens(0, 0, 5, 0),     -1, 0, 1, 1, 5,   4,   2);
    add(4'b1000, lens(1, 0, 0, 0),     -1, 0, 3, 3, 1,   0,   2);
    add(4'b1111, lens(3, 3, 3, 3),     -1, 0, 0, 0, 3,   2,   2);
    add(4'b1111, lens(3, 3, 3, 3),     -1, 0, 1, 0, 3,   2,   2);
    add(4'b1111, lens(3, 3, 3, 3),     -1, 0, 2, 0, 3,   2,   2);
    add(4'b1111, lens(3, 3, 3, 3),     -1, 0, 3, 0, 3,   2,   2);
    add(4'b1111, lens(3, 3, 3, 3),     -1, 0, 0, 0, 3,   2,   2);
    add(4'b0100, lens(0, 0, 0, 0),     -1, 0, 2, 2, 1,   0,   2);
    add(4'b0100, lens(0, 255, 0, 0),   -1, 0, 2, 2, 255, 254, 2);
    add(4'b1000, lens(8, 0, 0, 0),      2, 0, 3, 3, 3,   2,   2);
    add(4'b0011, lens(0, 0, 2, 2),     -1, 0, 0, 0, 2,   1,   2);
    add(4'b0011, lens(0, 0, 6, 6),     -1, 1, 1, 0, 6,   5,   2);
    add(4'b0100, lens(0, 2, 0, 0),     -1, 0, 2, 2, 2,   1,   2);
    add(4'b0101, lens(0, 2, 0, 2),     -1, 0, 0, 0, 2,   1,   2);
    add(4'b0101, lens(0, 2, 0, 2),     -1, 0, 2, 0, 2,   1,   2);
    add(4'b0101, lens(0, 2, 0, 2),     -1, 0, 0, 0, 2,   1,   2);
    add(4'b0101, lens(0, 2, 0, 2),     -1, 0, 2, 0, 2,   1,   2);

    // Reset lands mid-window at t=17 and is held for 11 time units.
    #2;
    reset = 1'b0;
    req = 4'b0010;
    len = lens(0, 0, 8, 0);
    #14;
    check("pre_reset_grant", int'(grant), 2);
    check("pre_reset_value", int'(value), 1);
    #1 reset = 1'b1;
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_done", int'(done), 0);
    check("reset_value", int'(value), 0);
    check("reset_busy", int'(busy), 0);
    req = 4'b1001;
    len = lens(0, 0, 0, 4);
    #10 reset = 1'b0;

    foreach (vecs[i]) run_entry(vecs[i]);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interval_sched.md
Name: interval_sched

Overview:
Scheduler that shares one WIDTH-bit interval counter between NREQ requesters.
- Each requester asks for a timed window of len cycles.
- The block arbitrates round-robin, grants one requester, runs the counter for the window, pulses done, and releases.
- Sits between client logic and the counter datapath: it owns load, clear and enable sequencing. Value is exported for observation.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, counter and length width in bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level; held until done or voluntary release
len  input  NREQ*WIDTH  window length; requester i uses bits [i*WIDTH +: WIDTH]; sampled at grant
grant  output  NREQ  one-hot grant; all zero when idle
busy  output  1  high in RUN or DONE
value  output  WIDTH  current count of the active window; 0 when idle
done  output  NREQ  one-cycle pulse to the released requester

Behaviour:
- Reset is asynchronous: state=IDLE, grant=0, done=0, busy=0, value=0, rr_ptr=0, len_l=0. Reset mid-window drops the grant immediately and emits no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, the winner is the first index i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping mod NREQ.
  - On the next edge: state=RUN, grant=onehot(winner), len_l=len[winner], cnt=0.
  - If req=0, stay in IDLE.
- RUN:
  - value=cnt; cnt increments by 1 each cycle.
  - Exit to DONE when any of these hold: cnt==len_l-1; len_l==0 (treated as 1 cycle); or req[winner] sampled low (early release).
  - Grant is high for exactly max(len_l,1) cycles unless released early.
  - Requests from other indices are ignored.
- DONE (1 cycle):
  - grant=0, done[winner]=1, value holds the last count.
  - rr_ptr=(winner+1) mod NREQ, then state=IDLE.
- IDLE value is 0. done is never asserted outside DONE.
- Back-to-back throughput is one window per len_l+2 cycles: 1 arbitration cycle, len_l RUN cycles, 1 DONE cycle.
- Counter arithmetic is unsigned WIDTH bits. len_l=2^WIDTH-1 gives 255 cycles at WIDTH=8. cnt never wraps because exit occurs at len_l-1.
- len changes after the grant edge have no effect, because len_l is latched.
- Simultaneous events:
  - Release and terminal count in the same cycle give a single DONE.
  - A new req arriving during DONE is considered in the following IDLE.
- Invariant: grant is one-hot or zero; $onehot0 assertion is compiled in simulation.

Optional Feature:
Macro INTERVAL_SCHED_PRIO_EN.
- Defined: index 0 is fixed highest priority. If req[0]=1 in IDLE it wins regardless of rr_ptr. Indices 1..NREQ-1 arbitrate round-robin among themselves, and rr_ptr only advances past non-zero winners. Preemption of a running window never occurs.
- Undefined: pure round-robin over all NREQ indices as above.

Decomposition:
- Package interval_sched_pkg holds the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default NREQ/WIDTH constants.
- One sub-module, rr_pick: combinational round-robin picker with inputs req and rr_ptr, outputs winner index and valid. It is parameterised by NREQ and honours INTERVAL_SCHED_PRIO_EN.
- The counter register stays in interval_sched.

Test Plan:
- Reset: assert reset at t=17 for 11 time units mid-stream -> grant=0, done=0, value=0, busy=0 immediately. After release, the first IDLE picks from index 0.
- Single request: req=4'b0010, len[1]=5 -> grant=4'b0010 for 5 cycles, value 0,1,2,3,4, then done=4'b0010 for 1 cycle, busy low 1 cycle later.
- Round-robin fairness: req=4'b1111 held, all len=3 -> grant order 0,1,2,3,0; each window 3 cycles; 5-cycle period.
- Zero length and max length: len[2]=0 -> 1 grant cycle, value=0. len[2]=255 -> 255 grant cycles, last value=254, no wrap.
- Early release: req[3] drops at cycle 2 of an 8-cycle window -> DONE next cycle, done[3] pulses, rr_ptr=0.
- With INTERVAL_SCHED_PRIO_EN: req=4'b0101 while 2 is running, then req[0] re-asserted every DONE -> 0 wins every arbitration. Without the macro, 0 and 2 alternate.
